unidade_controle_multiciclo: RTL
================================

UNIDADE_CONTROLE_MULTICICLO -- requirements
Module: unidade_controle_multiciclo

Interface
REQ-001 Parameter ULA_CTRL_W, default 3, SHALL be the width of ULA_Control; codes SHALL be AND=000, OR=001, ADD=010, SUB=110, SLT=111, zero-extended when ULA_CTRL_W>3.
REQ-002 Parameter EN_EXT, default 1, SHALL enable the extended opcodes bne 000101, andi 001100, ori 001101, slti 001010; when 0 these SHALL decode as illegal.
REQ-003 Parameter CNT_W, default 32, SHALL be the width of the retired-instruction counter.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 OP, Funct  in  6 each  instruction fields, sampled only in DECODE and the states after it.
REQ-007 mem_ready  in  1  memory handshake; 1 = access completes this cycle.
REQ-008 IorD, IRWrite, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, PCWrite, Branch, BranchNe, ZeroExt  out  1 each  datapath controls.
REQ-009 ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign/zero-ext imm, 11 imm<<2.
REQ-010 PCSrc  out  2  00 ULA result, 01 ALUOut, 10 jump target.
REQ-011 ULA_Control  out  ULA_CTRL_W  ULA operation.
REQ-012 retired  out  1  one-cycle pulse when an instruction completes.
REQ-013 instr_count  out  CNT_W  count of retired instructions.
REQ-014 illegal  out  1  sticky flag, set on unsupported OP or R-type Funct.

Function
REQ-015 FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC, ALUWB, IMMEXEC, IMMWB, BRANCH, JUMP, HALT.
REQ-016 Outputs SHALL be Moore (state only) except ULA_Control in EXEC (from Funct) and IMMEXEC (from OP); unlisted outputs SHALL be 0.
REQ-017 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ULA=ADD, PCSrc=00; holds while mem_ready=0; IRWrite=PCWrite=1 only in the cycle mem_ready=1, then -> DECODE.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ULA=ADD; next: lw/sw->MEMADR, R-type->EXEC, addi/andi/ori/slti->IMMEXEC, beq/bne->BRANCH, j->JUMP, else->HALT.
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; lw->MEMREAD, sw->MEMWRITE.
REQ-020 MEMREAD: IorD=1; waits on mem_ready, then -> MEMWB; MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
REQ-021 MEMWRITE: IorD=1, MemWrite=1 every cycle until mem_ready=1, then -> FETCH.
REQ-022 EXEC: ALUSrcA=1, ALUSrcB=00, Funct 100000/100010/100100/100101/101010 -> ADD/SUB/AND/OR/SLT; other Funct -> HALT; ALUWB: RegDst=1, RegWrite=1 -> FETCH.
REQ-023 IMMEXEC: ALUSrcA=1, ALUSrcB=10, ZeroExt=1 for andi/ori; ULA ADD/AND/OR/SLT; IMMWB: RegDst=0, RegWrite=1 -> FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, Branch=1 (beq) or BranchNe=1 (bne) -> FETCH.
REQ-025 JUMP: PCSrc=10, PCWrite=1 -> FETCH.
REQ-026 HALT: illegal=1, all write enables 0, state held until reset.
REQ-027 Latency with mem_ready=1: lw 5, sw/R-type/imm 4, beq/bne/j 3 cycles.
REQ-028 retired SHALL pulse in MEMWB, MEMWRITE (on mem_ready), ALUWB, IMMWB, BRANCH, JUMP; instr_count SHALL increment then and wrap from all-ones to 0.

Reset
REQ-029 rst_n low SHALL immediately force state=FETCH, instr_count=0, illegal=0 and every output 0, including mid-instruction and mid-wait.
REQ-030 First edge after rst_n rises SHALL be evaluated in FETCH.

Structure
REQ-031 State encoding, opcode/Funct constants and ULA codes SHALL live in shared package mips_ctrl_pkg.
REQ-032 Sub-module ula_decoder (OP, Funct, state class -> ULA_Control, legal flag) SHALL be instantiated once.

Verification
REQ-033 lw, mem_ready=1: FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 and MemtoReg=1 in cycle 5; instr_count 0->1.
REQ-034 sw with mem_ready low 3 cycles in MEMWRITE: MemWrite=1 for 4 cycles, retired once, total 7 cycles.
REQ-035 R-type Funct=101010: ULA_Control=111 in EXEC; Funct=000000: HALT, illegal=1, RegWrite never asserted.
REQ-036 bne with EN_EXT=1: BranchNe=1, ULA=110 in BRANCH; same OP with EN_EXT=0: HALT.
REQ-037 rst_n low in MEMREAD: outputs 0 asynchronously, restart in FETCH, instr_count=0.
REQ-038 CNT_W=4, 16 jumps: instr_count wraps 15->0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM states,
// opcode/Funct constants, ULA operation codes and the control bundle.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC,
    S_ALUWB, S_IMMEXEC, S_IMMWB, S_BRANCH, S_JUMP, S_HALT
  } state_e;

  // Tells the ULA decoder where the operation comes from in the current state
  typedef enum logic [2:0] {CLS_NONE, CLS_ADD, CLS_SUB, CLS_RTYPE, CLS_IMM} ula_cls_e;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic       zeroext;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       retired;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_SLT = 3'b111;

endpackage

// File: rtl/ula_decoder.sv
// ULA operation decoder: maps the state class plus OP/Funct to a 3-bit ULA
// code and flags Funct/OP values the selected class cannot execute.
module ula_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int EN_EXT = 1
) (
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  ula_cls_e   cls_i,
  output logic [2:0] ula_o,
  output logic       legal_o
);

  localparam bit Ext = (EN_EXT != 0);

  // Pure lookup; unknown codes fall back to AND (000) with legal_o low
  always_comb begin
    ula_o   = ULA_AND;
    legal_o = 1'b1;
    case (cls_i)
      CLS_ADD: ula_o = ULA_ADD;
      CLS_SUB: ula_o = ULA_SUB;
      CLS_RTYPE: begin
        case (funct_i)
          FN_ADD:  ula_o = ULA_ADD;
          FN_SUB:  ula_o = ULA_SUB;
          FN_AND:  ula_o = ULA_AND;
          FN_OR:   ula_o = ULA_OR;
          FN_SLT:  ula_o = ULA_SLT;
          default: legal_o = 1'b0;
        endcase
      end
      CLS_IMM: begin
        case (op_i)
          OP_ADDI: ula_o = ULA_ADD;
          OP_ANDI: begin ula_o = ULA_AND; legal_o = Ext; end
          OP_ORI:  begin ula_o = ULA_OR;  legal_o = Ext; end
          OP_SLTI: begin ula_o = ULA_SLT; legal_o = Ext; end
          default: legal_o = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle MIPS control unit: Moore FSM driving the datapath controls,
// with a retired-instruction counter and a sticky illegal-instruction flag.
module unidade_controle_multiciclo
  import mips_ctrl_pkg::*;
#(
  parameter int ULA_CTRL_W = 3,
  parameter int EN_EXT     = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            OP,
  input  logic [5:0]            Funct,
  input  logic                  mem_ready,
  output logic                  IorD,
  output logic                  IRWrite,
  output logic                  MemWrite,
  output logic                  MemtoReg,
  output logic                  RegDst,
  output logic                  RegWrite,
  output logic                  ALUSrcA,
  output logic                  PCWrite,
  output logic                  Branch,
  output logic                  BranchNe,
  output logic                  ZeroExt,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            PCSrc,
  output logic [ULA_CTRL_W-1:0] ULA_Control,
  output logic                  retired,
  output logic [CNT_W-1:0]      instr_count,
  output logic                  illegal
);

  localparam bit Ext = (EN_EXT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             illegal_q;
  ctrl_t            ctrl;
  ula_cls_e         cls;
  logic [2:0]       ula;
  logic             legal;

  ula_decoder #(.EN_EXT(EN_EXT)) u_ula_dec (
    .op_i    (OP),
    .funct_i (Funct),
    .cls_i   (cls),
    .ula_o   (ula),
    .legal_o (legal)
  );

  // State, retired counter and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ctrl.retired) cnt_q <= cnt_q + CNT_W'(1);
      if (state_d == S_HALT) illegal_q <= 1'b1;
    end
  end

  // Next state and Moore controls; everything is forced low while rst_n is
  // low so the outputs clear asynchronously with the reset.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    cls     = CLS_NONE;
    case (state_q)
      S_FETCH: begin
        ctrl.alusrcb = 2'b01;
        cls          = CLS_ADD;
        if (mem_ready) begin
          ctrl.irwrite = 1'b1;
          ctrl.pcwrite = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alusrcb = 2'b11;
        cls          = CLS_ADD;
        case (OP)
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_RTYPE:                 state_d = S_EXEC;
          OP_ADDI:                  state_d = S_IMMEXEC;
          OP_ANDI, OP_ORI, OP_SLTI: state_d = Ext ? S_IMMEXEC : S_HALT;
          OP_BEQ:                   state_d = S_BRANCH;
          OP_BNE:                   state_d = Ext ? S_BRANCH : S_HALT;
          OP_J:                     state_d = S_JUMP;
          default:                  state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        cls          = CLS_ADD;
        state_d      = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        ctrl.iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.retired  = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        if (mem_ready) begin
          ctrl.retired = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        cls          = CLS_RTYPE;
        state_d      = legal ? S_ALUWB : S_HALT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.retired  = 1'b1;
        state_d       = S_FETCH;
      end
      S_IMMEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.zeroext = (OP == OP_ANDI) || (OP == OP_ORI);
        cls          = CLS_IMM;
        state_d      = legal ? S_IMMWB : S_HALT;
      end
      S_IMMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.retired  = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alusrca  = 1'b1;
        ctrl.pcsrc    = 2'b01;
        ctrl.branch   = (OP == OP_BEQ);
        ctrl.branchne = (OP == OP_BNE);
        ctrl.retired  = 1'b1;
        cls           = CLS_SUB;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
        ctrl.retired = 1'b1;
        state_d      = S_FETCH;
      end
      S_HALT:  ;
      default: state_d = S_HALT;
    endcase
    if (!rst_n) ctrl = '0;
  end

  assign IorD        = ctrl.iord;
  assign IRWrite     = ctrl.irwrite;
  assign MemWrite    = ctrl.memwrite;
  assign MemtoReg    = ctrl.memtoreg;
  assign RegDst      = ctrl.regdst;
  assign RegWrite    = ctrl.regwrite;
  assign ALUSrcA     = ctrl.alusrca;
  assign PCWrite     = ctrl.pcwrite;
  assign Branch      = ctrl.branch;
  assign BranchNe    = ctrl.branchne;
  assign ZeroExt     = ctrl.zeroext;
  assign ALUSrcB     = ctrl.alusrcb;
  assign PCSrc       = ctrl.pcsrc;
  assign retired     = ctrl.retired;
  assign ULA_Control = rst_n ? ULA_CTRL_W'(ula) : '0;
  assign instr_count = cnt_q;
  assign illegal     = illegal_q;

endmodule
